// File: rtl/regfile_mp.sv
// regfile_mp: dual-write, NRD-read register file with a post-reset clear sweep.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     waddr0,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     waddr1,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic                  init_busy,
    output logic                  wr_collision
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   clr_ptr;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                keep0, keep1;

    // Writes to entry 0 are dropped when it is hardwired to zero.
    assign keep0 = we0 && !(ZERO_REG != 0 && waddr0 == '0);
    assign keep1 = we1 && !(ZERO_REG != 0 && waddr1 == '0);
    assign init_busy = state == CLEAR;

    always_comb begin
        state_n = (state == CLEAR && &clr_ptr) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CLEAR;
            clr_ptr      <= '0;
            wr_collision <= 1'b0;
        end else begin
            state        <= state_n;
            clr_ptr      <= state == CLEAR ? clr_ptr + ADDR_W'(1) : clr_ptr;
            wr_collision <= state == IDLE && we0 && we1 && waddr0 == waddr1;
        end
    end

    // Port 1 is assigned last so it wins a same-address dual write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else begin
                if (keep0) mem[waddr0] <= wdata0;
                if (keep1) mem[waddr1] <= wdata1;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] q;
        assign a = raddr[k*ADDR_W +: ADDR_W];
        always_comb begin
            q = mem[a];
`ifdef REGFILE_BYPASS_EN
            if (!rst && keep0 && a == waddr0) q = wdata0;
            if (!rst && keep1 && a == waddr1) q = wdata1;
`endif
            if (state == CLEAR || (ZERO_REG != 0 && a == '0)) q = '0;
        end
        assign rdata[k*DATA_W +: DATA_W] = q;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp at default parameters.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [4:0]  waddr0 = '0, waddr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic [9:0]  raddr = '0;
    logic [63:0] rdata;
    logic        init_busy, wr_collision;
    int          n_assert = 0;
    int          n_fail = 0;
    int          n_edges;

    regfile_mp dut (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata),
        .init_busy(init_busy), .wr_collision(wr_collision)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
        #1;
    endtask

    // Counts rising edges until init_busy falls, bounded at 40.
    task automatic wait_clear(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (init_busy && n < 40);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        we0 = 1'b0;
        we1 = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(init_busy), 32'd1);
        check("reset_coll", 32'(wr_collision), 32'd0);
        rd(5'd3, 5'd17);
        check("reset_rd0", rdata[31:0], 32'h0);
        check("reset_rd1", rdata[63:32], 32'h0);
        rst = 1'b0;
        wait_clear(n_edges);
        check("sweep_len", 32'(n_edges), 32'd32);
        check("sweep_done", 32'(init_busy), 32'd0);
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            check("clear_rd0", rdata[31:0], 32'h0);
            check("clear_rd1", rdata[63:32], 32'h0);
        end

        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        rd(5'd5, 5'd0);
`ifdef REGFILE_BYPASS_EN
        check("wr_same_cycle", rdata[31:0], 32'hDEADBEEF);
`else
        check("wr_same_cycle", rdata[31:0], 32'h0);
`endif
        @(negedge clk); idle_inputs(); #1;
        check("wr_next_cycle", rdata[31:0], 32'hDEADBEEF);

        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
        @(negedge clk); idle_inputs();
        rd(5'd0, 5'd7);
        check("coll_flag", 32'(wr_collision), 32'd1);
        check("coll_winner", rdata[63:32], 32'h22);
        @(negedge clk); #1;
        check("coll_flag_clr", 32'(wr_collision), 32'd0);

        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
        rd(5'd0, 5'd0);
        check("zero_same0", rdata[31:0], 32'h0);
        check("zero_same1", rdata[63:32], 32'h0);
        @(negedge clk); idle_inputs(); #1;
        check("zero_rd0", rdata[31:0], 32'h0);
        check("zero_rd1", rdata[63:32], 32'h0);

        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h5;
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'h6;
        @(negedge clk); idle_inputs(); #1;
        check("coll_addr0", 32'(wr_collision), 32'd1);
        check("zero_after_coll", rdata[31:0], 32'h0);

        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'hA5A5A5A5;
        rd(5'd5, 5'd9);
        check("indep_port0", rdata[31:0], 32'hDEADBEEF);
`ifdef REGFILE_BYPASS_EN
        check("bypass_p1", rdata[63:32], 32'hA5A5A5A5);
`else
        check("bypass_p1", rdata[63:32], 32'h0);
`endif
        @(negedge clk); idle_inputs();
        rd(5'd9, 5'd9);
        check("wr9_rd0", rdata[31:0], 32'hA5A5A5A5);
        check("wr9_rd1", rdata[63:32], 32'hA5A5A5A5);

        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h33;
        we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h44;
        @(negedge clk); idle_inputs();
        rd(5'd3, 5'd4);
        check("dual_rd0", rdata[31:0], 32'h33);
        check("dual_rd1", rdata[63:32], 32'h44);
        check("dual_no_coll", 32'(wr_collision), 32'd0);

        rst = 1'b1;
        we0 = 1'b1; waddr0 = 5'd20; wdata0 = 32'h1234;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        we1 = 1'b1; waddr1 = 5'd20; wdata1 = 32'h5678;
        rd(5'd5, 5'd20);
        check("sweep_busy", 32'(init_busy), 32'd1);
        check("sweep_rd0", rdata[31:0], 32'h0);
        check("sweep_rd1", rdata[63:32], 32'h0);
        check("sweep_no_coll", 32'(wr_collision), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_clear(n_edges);
        idle_inputs();
        check("resweep_len", 32'(n_edges), 32'd32);
        rd(5'd5, 5'd20);
        check("resweep_rd5", rdata[31:0], 32'h0);
        check("resweep_rd20", rdata[63:32], 32'h0);
        rd(5'd9, 5'd7);
        check("resweep_rd9", rdata[31:0], 32'h0);
        check("resweep_rd7", rdata[63:32], 32'h0);
        rd(5'd3, 5'd4);
        check("resweep_rd3", rdata[31:0], 32'h0);
        check("resweep_rd4", rdata[63:32], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The module SHALL expose these parameters:
- DATA_W, default 32: register width in bits.
- ADDR_W, default 5: address width; DEPTH = 2**ADDR_W entries.
- NRD, default 2: number of read ports.
- ZERO_REG, default 1: when 1, entry 0 is hardwired to zero.
REQ-002 The module SHALL use one clock; reset is synchronous and active-high.
REQ-003 The module SHALL have these ports (clock and reset first):
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- we0  in  1  write enable, port 0.
- waddr0  in  ADDR_W  write address, port 0.
- wdata0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1.
- waddr1  in  ADDR_W  write address, port 1.
- wdata1  in  DATA_W  write data, port 1.
- raddr  in  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rdata  out  NRD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
- init_busy  out  1  high while the clear sweep runs.
- wr_collision  out  1  registered one-cycle flag for a same-address dual write.

Function
REQ-004 The module SHALL implement a two-state FSM:
- CLEAR: sweep pointer clr_ptr (ADDR_W bits) active.
- IDLE: normal operation.
REQ-005 In CLEAR with rst=0, each rising edge SHALL write zero to mem[clr_ptr] and increment clr_ptr.
- When clr_ptr == DEPTH-1, the FSM SHALL go to IDLE on that edge.
REQ-006 init_busy SHALL be 1 exactly when the FSM is in CLEAR.
- After rst deasserts, it SHALL stay high for DEPTH rising edges.
REQ-007 In CLEAR, we0 and we1 SHALL be ignored and every rdata port SHALL read 0.
REQ-008 In IDLE, on each rising edge:
- if we0=1, mem[waddr0] <= wdata0;
- if we1=1, mem[waddr1] <= wdata1.
REQ-009 If we0=we1=1 and waddr0==waddr1, port 1 SHALL win.
- wr_collision SHALL be 1 in the following cycle only.
- This holds for address 0 as well.
REQ-010 With ZERO_REG=1:
- writes to address 0 SHALL be discarded;
- reads of address 0 SHALL return 0 on every port in every cycle.
REQ-011 With ZERO_REG=0, entry 0 SHALL behave as an ordinary register.
REQ-012 Reads SHALL be combinational from raddr; all NRD ports are independent and may target the same address.
REQ-013 A write SHALL be visible on rdata from the cycle after its write edge (except as in REQ-017).

Reset
REQ-014 A rising edge with rst=1 SHALL set FSM=CLEAR, clr_ptr=0 and wr_collision=0, and SHALL cancel any write that cycle.
REQ-015 rst asserted mid-sweep SHALL restart the sweep from entry 0.
REQ-016 rst asserted in IDLE SHALL re-run the full sweep, so all entries read 0 once init_busy falls.

Configuration
REQ-017 With macro REGFILE_BYPASS_EN defined, a read port whose raddr equals an active IDLE-state write address SHALL return that write's data combinationally in the same cycle.
- Port 1 wins over port 0 for the bypassed value.
- Address 0 SHALL NOT be bypassed when ZERO_REG=1.
REQ-018 Without REGFILE_BYPASS_EN, reads SHALL return only the stored contents; same-cycle writes appear next cycle.

Verification
REQ-019 The bench SHALL cover these scenarios (default parameters):
- Reset: rst high 2 cycles, then low -> init_busy high exactly 32 edges, then low; all 32 entries read 0.
- Basic write: IDLE, we0=1, waddr0=5, wdata0=0xDEADBEEF -> raddr port0=5 reads 0xDEADBEEF next cycle.
- Collision: we0=we1=1, both waddr=7, wdata0=0x11, wdata1=0x22 -> mem[7]=0x22; wr_collision=1 for one cycle.
- Zero register: we1=1, waddr1=0, wdata1=0xFFFFFFFF -> all ports read 0 at address 0 forever.
- Bypass: write 0xA5A5A5A5 to addr 9 with raddr port1=9 -> same cycle shows 0xA5A5A5A5 with REGFILE_BYPASS_EN; old value without it.
- Mid-sweep reset: rst pulsed at sweep entry 12 -> sweep restarts at 0; init_busy lasts 32 more edges; writes issued during the sweep are lost.
